// File: rtl/enemy_left_sprite.sv
// Left-side enemy sprite: walks from X_START toward X_STOP once per frame and emits a registered 12-bit pixel.
// Optional macro ENEMY_HIT_FLASH_EN adds a white FLASH phase between a hit and DEAD.
module enemy_left_sprite #(
    parameter int unsigned X_START        = 0,
    parameter int unsigned X_STOP         = 288,
    parameter int unsigned Y_POS          = 224,
    parameter int unsigned SPEED          = 2,
    parameter int unsigned ANIM_DIV       = 8,
    parameter int unsigned RESPAWN_FRAMES = 60,
    parameter logic [11:0] COLOR_A        = 12'hF00,
    parameter logic [11:0] COLOR_B        = 12'hA00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  state,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic        frame_tick,
    input  logic        hit,
    output logic [11:0] enemyL,
    output logic        reached,
    output logic        alive
);

    localparam int unsigned POS_W   = 10;
    localparam int unsigned SUM_W   = 11;
    localparam int unsigned SIZE    = 32;
    localparam int unsigned ANIM_W  = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int unsigned RESP_W  = (RESPAWN_FRAMES > 1) ? $clog2(RESPAWN_FRAMES) : 1;
    localparam logic [11:0] WHITE   = 12'hFFF;
`ifdef ENEMY_HIT_FLASH_EN
    localparam int unsigned FLASH_TICKS = 8;
    localparam int unsigned FLASH_W     = 3;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_WALK,
        S_REACHED,
        S_DEAD
`ifdef ENEMY_HIT_FLASH_EN
        , S_FLASH
`endif
    } fsm_t;

    fsm_t               fsm;
    logic [POS_W-1:0]   x_pos;
    logic [ANIM_W-1:0]  anim_cnt;
    logic               anim_bit;
    logic [RESP_W-1:0]  resp_cnt;
`ifdef ENEMY_HIT_FLASH_EN
    logic [FLASH_W-1:0] flash_cnt;
`endif

    logic [SUM_W-1:0]   step_sum;
    logic               alive_c;
    logic               flashing_c;
    logic [POS_W-1:0]   dx;
    logic [POS_W-1:0]   dy;
    logic               in_x;
    logic               in_y;
    logic               corner;
    logic               eye;
    logic [11:0]        pixel_c;

    // State decodes shared by the pixel path and the registered status outputs
    always_comb begin
        alive_c    = (fsm == S_WALK) || (fsm == S_REACHED);
        flashing_c = 1'b0;
`ifdef ENEMY_HIT_FLASH_EN
        alive_c    = alive_c || (fsm == S_FLASH);
        flashing_c = (fsm == S_FLASH);
`endif
    end

    assign step_sum = SUM_W'(x_pos) + SUM_W'(SPEED);

    // Sprite lookup; upper bounds widened to 11 bits so the box never wraps
    always_comb begin
        dx      = h_cnt - x_pos;
        dy      = v_cnt - POS_W'(Y_POS);
        in_x    = (h_cnt >= x_pos) &&
                  (SUM_W'(h_cnt) < (SUM_W'(x_pos) + SUM_W'(SIZE)));
        in_y    = (v_cnt >= POS_W'(Y_POS)) &&
                  (SUM_W'(v_cnt) < SUM_W'(Y_POS + SIZE));
        corner  = ((dx < 10'd4) || (dx > 10'd27)) && ((dy < 10'd4) || (dy > 10'd27));
        eye     = (dy >= 10'd8) && (dy <= 10'd11) &&
                  (((dx >= 10'd8) && (dx <= 10'd11)) || ((dx >= 10'd20) && (dx <= 10'd23)));
        pixel_c = 12'h000;
        if (alive_c && in_x && in_y && !corner) begin
            if (eye || flashing_c)
                pixel_c = WHITE;
            else
                pixel_c = anim_bit ? COLOR_B : COLOR_A;
        end
    end

    // Life-cycle FSM, position/animation/respawn counters and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm       <= S_IDLE;
            x_pos     <= POS_W'(X_START);
            anim_cnt  <= '0;
            anim_bit  <= 1'b0;
            resp_cnt  <= '0;
`ifdef ENEMY_HIT_FLASH_EN
            flash_cnt <= '0;
`endif
            enemyL    <= 12'h000;
            reached   <= 1'b0;
            alive     <= 1'b0;
        end else begin
            enemyL  <= pixel_c;
            reached <= (fsm == S_REACHED);
            alive   <= alive_c;
            if (state == 4'd0) begin
                fsm   <= S_IDLE;
                x_pos <= POS_W'(X_START);
            end else begin
                case (fsm)
                    S_IDLE: fsm <= S_WALK;
                    S_WALK: begin
                        if (hit) begin
`ifdef ENEMY_HIT_FLASH_EN
                            fsm       <= S_FLASH;
                            flash_cnt <= '0;
`else
                            fsm      <= S_DEAD;
                            resp_cnt <= '0;
`endif
                        end else if (frame_tick) begin
                            if (step_sum >= SUM_W'(X_STOP)) begin
                                x_pos <= POS_W'(X_STOP);
                                fsm   <= S_REACHED;
                            end else begin
                                x_pos <= step_sum[POS_W-1:0];
                            end
                            if (anim_cnt == ANIM_W'(ANIM_DIV - 1)) begin
                                anim_cnt <= '0;
                                anim_bit <= ~anim_bit;
                            end else begin
                                anim_cnt <= anim_cnt + 1'b1;
                            end
                        end
                    end
                    S_REACHED: fsm <= S_REACHED;
`ifdef ENEMY_HIT_FLASH_EN
                    S_FLASH: begin
                        if (frame_tick) begin
                            if (flash_cnt == FLASH_W'(FLASH_TICKS - 1)) begin
                                flash_cnt <= '0;
                                resp_cnt  <= '0;
                                fsm       <= S_DEAD;
                            end else begin
                                flash_cnt <= flash_cnt + 1'b1;
                            end
                        end
                    end
`endif
                    S_DEAD: begin
                        if (frame_tick) begin
                            if (resp_cnt == RESP_W'(RESPAWN_FRAMES - 1)) begin
                                resp_cnt <= '0;
                                x_pos    <= POS_W'(X_START);
                                anim_bit <= 1'b0;
                                fsm      <= S_WALK;
                            end else begin
                                resp_cnt <= resp_cnt + 1'b1;
                            end
                        end
                    end
                    default: fsm <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_enemy_left_sprite.sv
// Scoreboard bench for enemy_left_sprite: a behavioural model predicts each pixel and status bit per cycle.
module tb_enemy_left_sprite;

    localparam int X_START = 0;
    localparam int X_STOP  = 288;
    localparam int Y_POS   = 224;
    localparam int SPEED   = 2;
    localparam int ANIM_DIV = 8;
    localparam int RESPAWN = 60;
    localparam logic [11:0] COLOR_A = 12'hF00;
    localparam logic [11:0] COLOR_B = 12'hA00;
`ifdef ENEMY_HIT_FLASH_EN
    localparam bit FLASH_EN = 1'b1;
`else
    localparam bit FLASH_EN = 1'b0;
`endif

    localparam int ST_IDLE = 0, ST_WALK = 1, ST_REACHED = 2, ST_FLASH = 3, ST_DEAD = 4;

    logic        clk;
    logic        rst;
    logic [3:0]  game_state;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        frame_tick;
    logic        hit;
    logic [11:0] enemyL;
    logic        reached;
    logic        alive;

    enemy_left_sprite dut (
        .clk        (clk),
        .rst        (rst),
        .state      (game_state),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .frame_tick (frame_tick),
        .hit        (hit),
        .enemyL     (enemyL),
        .reached    (reached),
        .alive      (alive)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] pix;
        logic        alive;
        logic        reached;
    } exp_t;

    exp_t  sb[$];
    int    checks = 0;
    int    errors = 0;
    string phase  = "reset";

    int m_st, m_x, m_acnt, m_abit, m_rcnt, m_fcnt;

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s/%s got=%03h exp=%03h t=%0t", phase, tag, got, exp, $time);
        end
    endtask

    function automatic bit model_alive();
        return (m_st == ST_WALK) || (m_st == ST_REACHED) || (m_st == ST_FLASH);
    endfunction

    function automatic logic [11:0] model_pix(input int h, input int v);
        int dx, dy;
        bit edge_x, edge_y;
        dx = h - m_x;
        dy = v - Y_POS;
        if (!model_alive() || dx < 0 || dx >= 32 || dy < 0 || dy >= 32) return 12'h000;
        edge_x = (dx < 4) || (dx > 27);
        edge_y = (dy < 4) || (dy > 27);
        if (edge_x && edge_y) return 12'h000;
        if (m_st == ST_FLASH) return 12'hFFF;
        if (dy >= 8 && dy <= 11 && ((dx >= 8 && dx <= 11) || (dx >= 20 && dx <= 23))) return 12'hFFF;
        return (m_abit != 0) ? COLOR_B : COLOR_A;
    endfunction

    task automatic model_reset();
        m_st = ST_IDLE; m_x = X_START; m_acnt = 0; m_abit = 0; m_rcnt = 0; m_fcnt = 0;
    endtask

    task automatic model_step(input bit ft, input bit hv);
        if (game_state == 4'd0) begin
            m_st = ST_IDLE;
            m_x  = X_START;
        end else if (m_st == ST_IDLE) begin
            m_st = ST_WALK;
        end else if (m_st == ST_WALK) begin
            if (hv) begin
                if (FLASH_EN) begin m_st = ST_FLASH; m_fcnt = 0; end
                else begin m_st = ST_DEAD; m_rcnt = 0; end
            end else if (ft) begin
                if (m_x + SPEED >= X_STOP) begin m_x = X_STOP; m_st = ST_REACHED; end
                else m_x = m_x + SPEED;
                m_acnt++;
                if (m_acnt == ANIM_DIV) begin m_acnt = 0; m_abit = 1 - m_abit; end
            end
        end else if (m_st == ST_FLASH && ft) begin
            m_fcnt++;
            if (m_fcnt == 8) begin m_fcnt = 0; m_rcnt = 0; m_st = ST_DEAD; end
        end else if (m_st == ST_DEAD && ft) begin
            m_rcnt++;
            if (m_rcnt == RESPAWN) begin m_rcnt = 0; m_x = X_START; m_abit = 0; m_st = ST_WALK; end
        end
    endtask

    // One clock: drive inputs, push prediction, advance model, then pop and compare after the edge
    task automatic cyc(input bit ft, input bit hv, input int h, input int v);
        exp_t e;
        frame_tick = ft;
        hit        = hv;
        h_cnt      = 10'(h);
        v_cnt      = 10'(v);
        e.pix      = model_pix(h, v);
        e.alive    = model_alive();
        e.reached  = (m_st == ST_REACHED);
        sb.push_back(e);
        model_step(ft, hv);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("enemyL",  enemyL,           e.pix);
        check("alive",   {11'b0, alive},   {11'b0, e.alive});
        check("reached", {11'b0, reached}, {11'b0, e.reached});
    endtask

    task automatic rand_tick(input bit ft);
        cyc(ft, 1'b0, int'($urandom_range(0, 359)), int'($urandom_range(216, 262)));
    endtask

    initial begin
        rst = 1'b0; game_state = 4'd0; frame_tick = 1'b0; hit = 1'b0;
        h_cnt = '0; v_cnt = '0;
        model_reset();
        #2;
        check("rst_enemyL",  enemyL,           12'h000);
        check("rst_alive",   {11'b0, alive},   12'h000);
        check("rst_reached", {11'b0, reached}, 12'h000);
        #5 rst = 1'b1;

        phase = "start";
        for (int i = 0; i < 32; i++) cyc(1'b0, 1'b0, i, 224);
        cyc(1'b1, 1'b0, 8, 232);

        phase = "walk";
        game_state = 4'd1;
        cyc(1'b0, 1'b0, 0, 0);
        repeat (10) rand_tick(1'b1);
        cyc(1'b0, 1'b0, 36, 240);
        cyc(1'b0, 1'b0, 20, 224);
        cyc(1'b0, 1'b0, 28, 232);
        for (int h = 0; h < 64; h++) cyc(1'b0, 1'b0, h, 232);
        cyc(1'b0, 1'b0, 30, 255);

        phase = "sat";
        repeat (134) rand_tick(1'b1);
        repeat (2) cyc(1'b0, 1'b0, 304, 240);
        repeat (5) rand_tick(1'b1);
        cyc(1'b0, 1'b1, 304, 240);
        cyc(1'b1, 1'b1, 300, 240);
        for (int h = 280; h < 330; h++) cyc(1'b0, 1'b0, h, 226);

        phase = "start2";
        game_state = 4'd0;
        cyc(1'b0, 1'b0, 304, 240);
        cyc(1'b0, 1'b0, 16, 240);
        cyc(1'b0, 1'b0, 304, 240);

        phase = "hit";
        game_state = 4'd1;
        cyc(1'b0, 1'b0, 0, 0);
        repeat (20) rand_tick(1'b1);
        cyc(1'b1, 1'b1, 56, 240);
        cyc(1'b0, 1'b1, 40, 240);
        cyc(1'b0, 1'b0, 40, 240);
        repeat (FLASH_EN ? 8 : 0) cyc(1'b1, 1'b0, 40, 240);
        cyc(1'b0, 1'b0, 56, 240);
        cyc(1'b0, 1'b0, 56, 240);

        phase = "respawn";
        repeat (59) rand_tick(1'b1);
        cyc(1'b0, 1'b1, 16, 240);
        cyc(1'b1, 1'b0, 16, 240);
        cyc(1'b0, 1'b0, 16, 240);
        cyc(1'b0, 1'b0, 0, 240);
        cyc(1'b0, 1'b0, 32, 240);

        phase = "arst";
        repeat (3) rand_tick(1'b1);
        #2 rst = 1'b0;
        #1;
        check("arst_enemyL",  enemyL,           12'h000);
        check("arst_alive",   {11'b0, alive},   12'h000);
        check("arst_reached", {11'b0, reached}, 12'h000);
        model_reset();
        @(posedge clk);
        #1;
        check("arst_hold", enemyL, 12'h000);
        rst = 1'b1;
        repeat (12) rand_tick(1'b1);
        cyc(1'b0, 1'b0, 20, 240);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/enemy_left_sprite.md
Name: enemy_left_sprite

Overview:
- Generates the left-side enemy's per-pixel colour for the display compositor.
- Consumes the VGA scan position and game state, and tracks the enemy's position and life cycle once per frame.
- Emits `enemyL`, a 12-bit RGB value in which 12'h000 means transparent, so the downstream compositor shows the background there.
- Sits directly upstream of the compositor, in parallel with the background generator.

Parameters:
- `X_START`, 0: column at which the enemy spawns (left edge of the sprite).
- `X_STOP`, 288: column at which the enemy stops walking; the "reached" position.
- `Y_POS`, 224: top row of the sprite, fixed.
- `SPEED`, 2: pixels advanced per frame tick while walking.
- `ANIM_DIV`, 8: frame ticks per animation-frame toggle.
- `RESPAWN_FRAMES`, 60: frame ticks spent in DEAD before respawn.
- `COLOR_A`, 12'hF00: body colour, animation frame 0.
- `COLOR_B`, 12'hA00: body colour, animation frame 1.

Ports:
- `clk`  in  1: pixel clock.
- `rst`  in  1: reset, asynchronous, active-low. The block is in reset while `rst` = 0.
- `state`  in  4: game state. 4'd0 = start screen; any other value = playing.
- `h_cnt`  in  10: current scan column, 0..639.
- `v_cnt`  in  10: current scan row, 0..479.
- `frame_tick`  in  1: one-`clk` pulse per frame, at the start of vertical blanking.
- `hit`  in  1: one-`clk` pulse when the player's attack connects with this enemy.
- `enemyL`  out  12: sprite pixel colour; 12'h000 = transparent.
- `reached`  out  1: high while the FSM is in REACHED.
- `alive`  out  1: high in WALK, REACHED and FLASH.

Behaviour:
- Reset (`rst` = 0, asynchronous):
  - FSM = IDLE, `x_pos` = `X_START`.
  - Animation counter = 0, animation bit = 0, respawn counter = 0, flash counter = 0.
  - `enemyL` = 12'h000, `reached` = 0, `alive` = 0.
- FSM states: IDLE, WALK, REACHED, FLASH, DEAD.
- Start screen override: whenever `state` == 0, the next state is IDLE and `x_pos` returns to `X_START`, regardless of the current state. This also covers a return to the start screen mid-game.
- IDLE -> WALK on the first `clk` with `state` != 0.
- WALK, on each `frame_tick`:
  - `x_pos` += `SPEED`, computed in 11 bits.
  - If the result is >= `X_STOP`: `x_pos` = `X_STOP` (saturated) and the next state is REACHED.
  - The animation counter increments. When it hits `ANIM_DIV`-1 it clears and the animation bit toggles.
- WALK, `hit` = 1: go to FLASH (or DEAD, see Optional Feature).
  - If `hit` and `frame_tick` arrive in the same cycle, `hit` wins and there is no movement that frame.
- REACHED:
  - Holds position; animation frozen.
  - `hit` is ignored.
  - Leaves only via the start screen override or reset.
- DEAD:
  - The sprite is not drawn.
  - The respawn counter counts `frame_tick`s. On reaching `RESPAWN_FRAMES`-1 it clears, `x_pos` = `X_START`, animation bit = 0, and the next state is WALK.
  - `hit` is ignored.
- Sprite geometry:
  - The box is 32x32: inside when `x_pos` <= `h_cnt` < `x_pos`+32 and `Y_POS` <= `v_cnt` < `Y_POS`+32.
  - The upper bounds are compared in 11 bits, so there is no wrap at the right edge.
  - Let dx = `h_cnt` - `x_pos` and dy = `v_cnt` - `Y_POS`. The four 4x4 corners (dx<4 or dx>27, and dy<4 or dy>27) are transparent.
  - Eyes: dy in 8..11 with dx in 8..11 or 20..23 gives 12'hFFF.
  - Every other inside pixel is `COLOR_A` when the animation bit is 0, `COLOR_B` when it is 1.
  - Outside the box, or in IDLE/DEAD: 12'h000.
- Pixel timing:
  - `enemyL` is registered: exactly 1 `clk` latency from `h_cnt`/`v_cnt`.
  - The pixel uses the `x_pos`, FSM state and animation bit as they stand in the cycle of the lookup.
  - `x_pos` changes only on `frame_tick`, i.e. in blanking, so there is no tearing.
- `reached` and `alive` are registered decodes of the FSM state, so they change in the cycle after the transition.

Optional Feature:
- Macro `ENEMY_HIT_FLASH_EN`.
- Defined:
  - A `hit` in WALK goes to FLASH.
  - In FLASH, every inside non-corner pixel is 12'hFFF; eyes are also white.
  - The flash counter counts 8 `frame_tick`s, then the FSM goes to DEAD.
  - A further `hit` during FLASH is ignored.
- Undefined:
  - The FLASH state and flash counter are absent.
  - A `hit` in WALK goes directly to DEAD; `alive` drops the next `clk`.

Test Plan:
- Reset and start screen: `rst` = 0, then 1, with `state` = 0. Scan across `h_cnt`=0..31, `v_cnt`=224 -> `enemyL` = 12'h000 throughout, `alive` = 0.
- Walk and draw: `state` = 1; apply 10 `frame_tick`s -> `x_pos` = 20. Drive `h_cnt`=36, `v_cnt`=240 -> one `clk` later `enemyL` = `COLOR_B` (animation toggled at tick 8). `h_cnt`=20, `v_cnt`=224 (corner) -> 12'h000. `h_cnt`=28, `v_cnt`=232 (eye) -> 12'hFFF.
- Saturation: 144 ticks -> `x_pos` = 288, `reached` = 1. Further ticks and a `hit` -> `x_pos` stays 288, `reached` stays 1.
- Hit priority: `hit` and `frame_tick` in the same `clk` at `x_pos`=40 -> `x_pos` stays 40.
  - With `ENEMY_HIT_FLASH_EN`: white for 8 ticks, then `enemyL` = 0 and `alive` = 0.
  - Without: `alive` = 0 on the next `clk`.
- Respawn: 60 ticks in DEAD -> WALK, `x_pos` = 0, `enemyL` = `COLOR_A` at `h_cnt`=16, `v_cnt`=240.
- Mid-game reset: assert `rst` = 0 asynchronously between clock edges while in WALK -> all outputs 0 immediately. Drop to `state` = 0 while in REACHED -> IDLE and `x_pos` = 0 on the next `clk`.
